// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver with configurable data width
// and parity, feeding a show-ahead receive FIFO with error reporting.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   rxd        serial input, idles high, asynchronous to clk
//   rd_en      pop the FIFO head (ignored while empty)
//   clr_err    clear the sticky overrun flag
//   rd_data    oldest FIFO entry, valid while empty = 0 (reads 0 when empty)
//   empty      FIFO holds no entries
//   full       FIFO holds FIFO_DEPTH entries
//   count      FIFO occupancy
//   overrun    sticky: a good frame was dropped because the FIFO was full
//   frame_err  one-cycle pulse: stop bit sampled low
//   parity_err one-cycle pulse: parity mismatch with a good stop bit
//
// Receiver FSM
//   state     | meaning
//   IDLE      | waiting for a falling edge on the synchronised line
//   START     | counting to mid start bit, rejects glitches
//   DATA      | sampling DATA_BITS data bits, LSB first
//   PAR       | sampling the parity bit
//   STOP      | sampling the stop bit, push or report an error
//   WAIT_HIGH | line held low after a framing error, wait for idle
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               rxd,
   input  logic                               rd_en,
   input  logic                               clr_err,
   output logic [DATA_BITS-1:0]               rd_data,
   output logic                               empty,
   output logic                               full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
   output logic                               overrun,
   output logic                               frame_err,
   output logic                               parity_err
);

   localparam int DIV   = CLK_FREQ / (BAUD * 16);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = $clog2(FIFO_DEPTH + 1);
   localparam int BW    = $clog2(DATA_BITS + 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PAR       = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

   logic                 rxd_meta;
   logic                 rxd_sync;
   logic [2:0]           state;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick;
   logic [3:0]           tick_cnt;
   logic                 sample;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;
   logic                 push;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic                 pop;
   logic                 wr;
   logic                 ovf;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_sync <= rxd_meta;
      end
   end

   // Oversample divider: down-counter held at DIV-1 in IDLE so the first
   // tick lands a full DIV period after the start edge is seen.
   assign tick = (state != ST_IDLE) && (div_cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else if (state == ST_IDLE || div_cnt == '0) begin
         div_cnt <= DIV_W'(DIV - 1);
      end else begin
         div_cnt <= div_cnt - DIV_W'(1);
      end
   end

   // Ticks remaining to the next mid-bit sample: 8 to mid start bit, then 16.
   assign sample = tick && (tick_cnt == 4'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= 4'd7;
      end else if (state == ST_IDLE) begin
         tick_cnt <= 4'd7;
      end else if (sample) begin
         tick_cnt <= 4'd15;
      end else if (tick) begin
         tick_cnt <= tick_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bad    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rxd_sync) state <= ST_START;
            end
            ST_START: begin
               if (sample) begin
                  if (!rxd_sync) begin
                     state   <= ST_DATA;
                     bit_cnt <= BW'(DATA_BITS);
                     par_bad <= 1'b0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               if (sample) begin
                  shreg   <= {rxd_sync, shreg[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt - BW'(1);
                  if (bit_cnt == BW'(1)) state <= (PARITY != 0) ? ST_PAR : ST_STOP;
               end
            end
            ST_PAR: begin
               if (sample) begin
                  // Even parity wants an XOR of 0, odd wants 1.
                  par_bad <= (^shreg) ^ rxd_sync ^ (PARITY == 2);
                  state   <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (sample) begin
                  if (!rxd_sync) begin
                     frame_err <= 1'b1;
                     state     <= ST_WAIT_HIGH;
                  end else begin
                     parity_err <= par_bad;
                     state      <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               if (rxd_sync) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign push = (state == ST_STOP) && sample && rxd_sync && !par_bad;

   // A pop while full frees the slot the same-cycle push needs.
   assign pop = rd_en && !empty;
   assign wr  = push && (!full || pop);
   assign ovf = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({wr, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         overrun <= ovf | (overrun & ~clr_err);
      end
   end

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   // DIV = 3_200_000 / (100_000 * 16) = 2 -> 32 clk cycles per bit
   localparam int CLK_FREQ = 3_200_000;
   localparam int BAUD     = 100_000;
   localparam int BIT      = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       rxd_a, rd_en_a, clr_err_a;
   logic [7:0] rd_data_a;
   logic       empty_a, full_a, overrun_a, frame_err_a, parity_err_a;
   logic [2:0] count_a;
   logic       rxd_b, rd_en_b, clr_err_b;
   logic [6:0] rd_data_b;
   logic       empty_b, full_b, overrun_b, frame_err_b, parity_err_b;
   logic [2:0] count_b;

   uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_dut_a (
      .clk(clk), .reset(reset), .rxd(rxd_a), .rd_en(rd_en_a), .clr_err(clr_err_a),
      .rd_data(rd_data_a), .empty(empty_a), .full(full_a), .count(count_a),
      .overrun(overrun_a), .frame_err(frame_err_a), .parity_err(parity_err_a));

   uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1), .FIFO_DEPTH(4)) u_dut_b (
      .clk(clk), .reset(reset), .rxd(rxd_b), .rd_en(rd_en_b), .clr_err(clr_err_b),
      .rd_data(rd_data_b), .empty(empty_b), .full(full_b), .count(count_b),
      .overrun(overrun_b), .frame_err(frame_err_b), .parity_err(parity_err_b));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Error pulses counted in high cycles, so a stretched pulse shows up as extra.
   int ferr_a = 0, perr_a = 0, ferr_b = 0, perr_b = 0;
   always @(negedge clk) begin
      if (frame_err_a)  ferr_a++;
      if (parity_err_a) perr_a++;
      if (frame_err_b)  ferr_b++;
      if (parity_err_b) perr_b++;
   end

   // Cycle of the very first occupancy increase on instance A.
   int push_cyc = -1;
   int prev_cnt_a = 0;
   always @(negedge clk) begin
      if (int'(count_a) > prev_cnt_a && push_cyc < 0) push_cyc = cyc;
      prev_cnt_a = int'(count_a);
   end

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic       bad_par;
      logic       stop;
      int         per;
      logic       exp_push;
      logic       exp_ferr;
      logic       exp_perr;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_line(input int sel, input logic v);
      if (sel == 0) rxd_a = v;
      else          rxd_b = v;
   endtask

   function automatic logic [9:0] mk_a(input logic [7:0] d, input logic stop);
      return {stop, d, 1'b0};
   endfunction

   function automatic logic [9:0] mk_b(input logic [6:0] d, input logic par, input logic stop);
      return {stop, par, d, 1'b0};
   endfunction

   task automatic drive_frame(input int sel, input logic [9:0] bits, input int per, input int nb);
      for (int i = 0; i < nb; i++) begin
         set_line(sel, bits[i]);
         repeat (per) @(negedge clk);
      end
   endtask

   task automatic send(input int sel, input logic [9:0] bits, input int per);
      drive_frame(sel, bits, per, 10);
      set_line(sel, 1'b1);
      repeat (64) @(negedge clk);
   endtask

   task automatic pop_chk(input int sel, input int exp, input string name);
      if (sel == 0) begin
         chk(name, int'(rd_data_a), exp);
         rd_en_a = 1'b1; @(negedge clk); rd_en_a = 1'b0;
      end else begin
         chk(name, int'(rd_data_b), exp);
         rd_en_b = 1'b1; @(negedge clk); rd_en_b = 1'b0;
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, " rd_data"}, int'(rd_data_a), 0);
      chk({tag, " empty"}, int'(empty_a), 1);
      chk({tag, " full"}, int'(full_a), 0);
      chk({tag, " count"}, int'(count_a), 0);
      chk({tag, " overrun"}, int'(overrun_a), 0);
      chk({tag, " frame_err"}, int'(frame_err_a), 0);
      chk({tag, " parity_err"}, int'(parity_err_a), 0);
   endtask

   initial begin
      int t0, push_off, f0, p0, fb0, pb0, d, st, per, n;
      int q[$];
      int ovr_m;
      logic [9:0] bits;

      vecs[0] = '{0, 8'h01, 1'b0, 1'b1, 32, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{0, 8'hFF, 1'b0, 1'b1, 31, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{0, 8'h00, 1'b0, 1'b1, 33, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{0, 8'h80, 1'b0, 1'b0, 32, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{1, 8'h7F, 1'b0, 1'b1, 32, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{1, 8'h35, 1'b1, 1'b1, 33, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{1, 8'h00, 1'b1, 1'b0, 32, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1, 8'h2A, 1'b0, 1'b1, 31, 1'b1, 1'b0, 1'b0};

      reset = 1'b0;
      rxd_a = 1'b1; rd_en_a = 1'b0; clr_err_a = 1'b0;
      rxd_b = 1'b1; rd_en_b = 1'b0; clr_err_b = 1'b0;
      repeat (5) @(negedge clk);
      chk_reset_a("reset");
      chk("reset empty b", int'(empty_b), 1);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // First frame 0x01 8N1, also measures start-edge-to-push latency.
      t0 = cyc;
      send(0, mk_a(8'h01, 1'b1), BIT);
      chk("0x01 empty", int'(empty_a), 0);
      chk("0x01 count", int'(count_a), 1);
      chk("0x01 errs", ferr_a + perr_a, 0);
      push_off = push_cyc - t0;
      // 2 + (8 + 16*9) * DIV = 306, allowed +-DIV
      chk("push latency in range", int'(push_off >= 304 && push_off <= 308), 1);
      if (push_off < 2 || push_off > 400) push_off = 306;
      pop_chk(0, 8'h01, "0x01 rd_data");
      chk("0x01 empty after pop", int'(empty_a), 1);
      chk("0x01 count after pop", int'(count_a), 0);

      // Short low glitch on an idle line.
      f0 = ferr_a; p0 = perr_a;
      rxd_a = 1'b0; repeat (4) @(negedge clk); rxd_a = 1'b1;
      repeat (200) @(negedge clk);
      chk("glitch count", int'(count_a), 0);
      chk("glitch errs", (ferr_a - f0) + (perr_a - p0), 0);

      // Table-driven frames on both instances.
      for (int i = 0; i < 8; i++) begin
         f0 = ferr_a; p0 = perr_a; fb0 = ferr_b; pb0 = perr_b;
         if (vecs[i].sel == 0) bits = mk_a(vecs[i].data, vecs[i].stop);
         else bits = mk_b(vecs[i].data[6:0], (^vecs[i].data[6:0]) ^ vecs[i].bad_par, vecs[i].stop);
         send(vecs[i].sel, bits, vecs[i].per);
         if (vecs[i].sel == 0) begin
            chk($sformatf("vec%0d ferr", i), ferr_a - f0, int'(vecs[i].exp_ferr));
            chk($sformatf("vec%0d perr", i), perr_a - p0, int'(vecs[i].exp_perr));
            chk($sformatf("vec%0d count", i), int'(count_a), int'(vecs[i].exp_push));
            if (vecs[i].exp_push) pop_chk(0, int'(vecs[i].data), $sformatf("vec%0d rd_data", i));
         end else begin
            chk($sformatf("vec%0d ferr", i), ferr_b - fb0, int'(vecs[i].exp_ferr));
            chk($sformatf("vec%0d perr", i), perr_b - pb0, int'(vecs[i].exp_perr));
            chk($sformatf("vec%0d count", i), int'(count_b), int'(vecs[i].exp_push));
            if (vecs[i].exp_push) pop_chk(1, int'(vecs[i].data[6:0]), $sformatf("vec%0d rd_data", i));
         end
      end

      // Bad stop bit followed by a break: one frame_err only.
      f0 = ferr_a; p0 = perr_a;
      drive_frame(0, mk_a(8'h55, 1'b0), BIT, 10);
      repeat (3 * BIT) @(negedge clk);
      rxd_a = 1'b1;
      repeat (64) @(negedge clk);
      chk("break ferr pulses", ferr_a - f0, 1);
      chk("break perr", perr_a - p0, 0);
      chk("break count", int'(count_a), 0);
      send(0, mk_a(8'hA3, 1'b1), BIT);
      chk("after break count", int'(count_a), 1);
      pop_chk(0, 8'hA3, "after break rd_data");

      // 7E1 parity: 0x35 has four ones, so the even parity bit is 0.
      pb0 = perr_b; fb0 = ferr_b;
      send(1, mk_b(7'h35, 1'b1, 1'b1), BIT);
      chk("bad parity perr", perr_b - pb0, 1);
      chk("bad parity count", int'(count_b), 0);
      send(1, mk_b(7'h35, 1'b0, 1'b1), BIT);
      chk("good parity perr", perr_b - pb0, 1);
      chk("good parity ferr", ferr_b - fb0, 0);
      pop_chk(1, 7'h35, "good parity rd_data");

      // Overrun: five frames into a four-entry FIFO.
      for (int i = 0; i < 5; i++) send(0, mk_a(8'(8'h10 + i), 1'b1), BIT);
      chk("ovr count", int'(count_a), 4);
      chk("ovr full", int'(full_a), 1);
      chk("ovr overrun", int'(overrun_a), 1);
      for (int i = 0; i < 4; i++) pop_chk(0, 8'h10 + i, $sformatf("ovr rd %0d", i));
      chk("ovr empty", int'(empty_a), 1);
      chk("ovr sticky", int'(overrun_a), 1);
      clr_err_a = 1'b1; @(negedge clk); clr_err_a = 1'b0;
      chk("ovr cleared", int'(overrun_a), 0);

      // Push and pop on the same edge while full.
      for (int i = 0; i < 4; i++) send(0, mk_a(8'(8'h20 + i), 1'b1), BIT);
      fork
         send(0, mk_a(8'h24, 1'b1), BIT);
         begin
            repeat (push_off - 1) @(negedge clk);
            rd_en_a = 1'b1; @(negedge clk); rd_en_a = 1'b0;
         end
      join
      chk("full push+pop count", int'(count_a), 4);
      chk("full push+pop full", int'(full_a), 1);
      chk("full push+pop overrun", int'(overrun_a), 0);
      for (int i = 1; i < 5; i++) pop_chk(0, 8'h20 + i, $sformatf("full push+pop rd %0d", i));

      // Push and pop on the same edge while empty: the pop is ignored.
      fork
         send(0, mk_a(8'h33, 1'b1), BIT);
         begin
            repeat (push_off - 1) @(negedge clk);
            rd_en_a = 1'b1; @(negedge clk); rd_en_a = 1'b0;
         end
      join
      chk("empty push+pop count", int'(count_a), 1);
      pop_chk(0, 8'h33, "empty push+pop rd_data");

      // Reset in the middle of 0x7E with one entry already queued.
      send(0, mk_a(8'h11, 1'b1), BIT);
      f0 = ferr_a; p0 = perr_a;
      drive_frame(0, mk_a(8'h7E, 1'b1), BIT, 5);
      reset = 1'b0;
      @(negedge clk);
      chk_reset_a("midframe reset");
      rxd_a = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (400) @(negedge clk);
      chk("post reset count", int'(count_a), 0);
      chk("post reset errs", (ferr_a - f0) + (perr_a - p0), 0);
      send(0, mk_a(8'h42, 1'b1), BIT);
      chk("post reset 0x42 count", int'(count_a), 1);
      pop_chk(0, 8'h42, "post reset 0x42 rd_data");

      // Randomised traffic against a queue model.
      ovr_m = 0;
      for (int it = 0; it < 20; it++) begin
         n = $urandom_range(0, 2);
         for (int k = 0; k < n; k++) begin
            if (q.size() > 0) begin
               pop_chk(0, q[0], "rand pop");
               void'(q.pop_front());
            end else begin
               rd_en_a = 1'b1; @(negedge clk); rd_en_a = 1'b0;
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            clr_err_a = 1'b1; @(negedge clk); clr_err_a = 1'b0;
            ovr_m = 0;
         end
         d   = $urandom_range(0, 255);
         st  = ($urandom_range(0, 5) != 0) ? 1 : 0;
         per = $urandom_range(31, 33);
         f0  = ferr_a;
         send(0, mk_a(8'(d), st[0]), per);
         if (st == 0)            chk("rand ferr", ferr_a - f0, 1);
         else begin
            chk("rand ferr", ferr_a - f0, 0);
            if (q.size() < 4) q.push_back(d);
            else              ovr_m = 1;
         end
         chk("rand count", int'(count_a), q.size());
         chk("rand full", int'(full_a), int'(q.size() == 4));
         chk("rand overrun", int'(overrun_a), ovr_m);
         if (q.size() > 0) chk("rand head", int'(rd_data_a), q[0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
